// File: rtl/axi4_wresp_gen_pkg.sv
// Shared definitions for the AXI4 write-response generator: BRESP encodings
// and a pointer-width helper for the non-power-of-two command FIFO.
package axi4_wresp_gen_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axi4_wresp_gen_fifo.sv
// Small synchronous FIFO for any depth (pointers wrap explicitly).
// A push while full or a pop while empty is ignored.
module axi4_wresp_gen_fifo
   import axi4_wresp_gen_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers/count define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/axi4_wresp_gen.sv
// AXI4 write-response slave endpoint: discards W data and answers each WLAST
// burst, in AW order, with one B carrying the AWID and RESP_CODE.
// Optional feature macro WRESP_GEN_USER_EN: carry AWUSER through to BUSER.
module axi4_wresp_gen
   import axi4_wresp_gen_pkg::*;
#(
   parameter int unsigned ID_WIDTH        = 1,
   parameter int unsigned USER_WIDTH      = 1,
   parameter int unsigned ADDR_FIFO_DEPTH = 3,
   parameter logic [1:0]  RESP_CODE       = RESP_DECERR
) (
   input  logic                  ACLK,
   input  logic                  sysReset,
   input  logic [ID_WIDTH-1:0]   SLAVE_AWID,
   input  logic [USER_WIDTH-1:0] SLAVE_AWUSER,
   input  logic                  SLAVE_AWVALID,
   output logic                  SLAVE_AWREADY,
   input  logic                  SLAVE_WLAST,
   input  logic                  SLAVE_WVALID,
   output logic                  SLAVE_WREADY,
   output logic [ID_WIDTH-1:0]   SLAVE_BID,
   output logic [1:0]            SLAVE_BRESP,
   output logic [USER_WIDTH-1:0] SLAVE_BUSER,
   output logic                  SLAVE_BVALID,
   input  logic                  SLAVE_BREADY
);

   // Handshakes: a transfer happens on the rising edge where VALID and READY
   // are both high; B payload is held stable while BVALID && !BREADY.

`ifdef WRESP_GEN_USER_EN
   localparam int unsigned FW = ID_WIDTH + USER_WIDTH;
`else
   localparam int unsigned FW = ID_WIDTH;
`endif
   localparam int unsigned CW = $clog2(ADDR_FIFO_DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(ADDR_FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          accept_en;
   logic          fifo_full;
   logic          fifo_empty;
   logic [FW-1:0] fifo_din;
   logic [FW-1:0] fifo_dout;
   logic [CW-1:0] wdone_cnt;
   logic [CW-1:0] wdone_nxt;
   logic          aw_fire;
   logic          w_done;
   logic          b_load;
   logic [ID_WIDTH-1:0] bid_q;
   logic [1:0]          bresp_q;
   logic                bvalid_q;

   // Readies stay low through reset and rise on the first edge after release.
   always_ff @(posedge ACLK or posedge sysReset) begin
      if (sysReset) accept_en <= 1'b0;
      else          accept_en <= 1'b1;
   end

   assign SLAVE_AWREADY = accept_en && !fifo_full;
   assign SLAVE_WREADY  = accept_en && (wdone_cnt != CNT_MAX);
   assign aw_fire       = SLAVE_AWVALID && SLAVE_AWREADY;
   assign w_done        = SLAVE_WVALID && SLAVE_WREADY && SLAVE_WLAST;
   assign b_load        = !fifo_empty && (wdone_cnt != '0) && (!bvalid_q || SLAVE_BREADY);

`ifdef WRESP_GEN_USER_EN
   assign fifo_din = {SLAVE_AWUSER, SLAVE_AWID};
`else
   assign fifo_din = SLAVE_AWID;
   logic unused_awuser;
   assign unused_awuser = ^SLAVE_AWUSER;
`endif

   axi4_wresp_gen_fifo #(
      .WIDTH (FW),
      .DEPTH (ADDR_FIFO_DEPTH)
   ) cmd_fifo (
      .clk       (ACLK),
      .rst       (sysReset),
      .push      (aw_fire),
      .push_data (fifo_din),
      .pop       (b_load),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A burst finishing in the same cycle one is answered leaves the count as is.
   always_comb begin
      wdone_nxt = wdone_cnt;
      if (w_done && !b_load)      wdone_nxt = wdone_cnt + CNT_ONE;
      else if (!w_done && b_load) wdone_nxt = wdone_cnt - CNT_ONE;
   end

   always_ff @(posedge ACLK or posedge sysReset) begin
      if (sysReset) begin
         wdone_cnt <= '0;
         bid_q     <= '0;
         bresp_q   <= '0;
         bvalid_q  <= 1'b0;
      end else begin
         wdone_cnt <= wdone_nxt;
         if (b_load) begin
            bid_q    <= fifo_dout[ID_WIDTH-1:0];
            bresp_q  <= RESP_CODE;
            bvalid_q <= 1'b1;
         end else if (bvalid_q && SLAVE_BREADY) begin
            bvalid_q <= 1'b0;
         end
      end
   end

`ifdef WRESP_GEN_USER_EN
   logic [USER_WIDTH-1:0] buser_q;
   always_ff @(posedge ACLK or posedge sysReset) begin
      if (sysReset)    buser_q <= '0;
      else if (b_load) buser_q <= fifo_dout[FW-1:ID_WIDTH];
   end
   assign SLAVE_BUSER = buser_q;
`else
   assign SLAVE_BUSER = '0;
`endif

   assign SLAVE_BID    = bid_q;
   assign SLAVE_BRESP  = bresp_q;
   assign SLAVE_BVALID = bvalid_q;

endmodule

// File: tb/tb_axi4_wresp_gen.sv
// Self-checking bench for axi4_wresp_gen: table-driven transactions, hand-written
// corner sequences, and a B-channel scoreboard fed by an expected queue.
module tb_axi4_wresp_gen;

   localparam int unsigned IDW = 4;
   localparam int unsigned UW  = 2;
   localparam int unsigned EW  = UW + IDW + 2;
   localparam logic [1:0]  EXP_RESP = 2'b11;

   logic           ACLK;
   logic           sysReset;
   logic [IDW-1:0] SLAVE_AWID;
   logic [UW-1:0]  SLAVE_AWUSER;
   logic           SLAVE_AWVALID;
   logic           SLAVE_AWREADY;
   logic           SLAVE_WLAST;
   logic           SLAVE_WVALID;
   logic           SLAVE_WREADY;
   logic [IDW-1:0] SLAVE_BID;
   logic [1:0]     SLAVE_BRESP;
   logic [UW-1:0]  SLAVE_BUSER;
   logic           SLAVE_BVALID;
   logic           SLAVE_BREADY;

   axi4_wresp_gen #(
      .ID_WIDTH        (IDW),
      .USER_WIDTH      (UW),
      .ADDR_FIFO_DEPTH (3),
      .RESP_CODE       (2'b11)
   ) dut (
      .ACLK          (ACLK),
      .sysReset      (sysReset),
      .SLAVE_AWID    (SLAVE_AWID),
      .SLAVE_AWUSER  (SLAVE_AWUSER),
      .SLAVE_AWVALID (SLAVE_AWVALID),
      .SLAVE_AWREADY (SLAVE_AWREADY),
      .SLAVE_WLAST   (SLAVE_WLAST),
      .SLAVE_WVALID  (SLAVE_WVALID),
      .SLAVE_WREADY  (SLAVE_WREADY),
      .SLAVE_BID     (SLAVE_BID),
      .SLAVE_BRESP   (SLAVE_BRESP),
      .SLAVE_BUSER   (SLAVE_BUSER),
      .SLAVE_BVALID  (SLAVE_BVALID),
      .SLAVE_BREADY  (SLAVE_BREADY)
   );

   // ---------------- clock ----------------
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expired, expected bench completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [UW-1:0] user_exp(input logic [UW-1:0] u);
`ifdef WRESP_GEN_USER_EN
      return u;
`else
      return '0;
`endif
   endfunction

   task automatic expect_b(input logic [IDW-1:0] id, input logic [UW-1:0] user);
      exp_q.push_back({user_exp(user), id, EXP_RESP});
   endtask

   // Inputs only change 1 time unit after posedge, so at negedge a visible
   // BVALID && BREADY is the handshake about to complete on the next edge.
   always @(negedge ACLK) begin
      if (!sysReset && SLAVE_BVALID && SLAVE_BREADY) begin
         check("b_expected_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check("b_bid",   32'(SLAVE_BID),   32'(exp_e[IDW+1:2]));
            check("b_bresp", 32'(SLAVE_BRESP), 32'(exp_e[1:0]));
            check("b_buser", 32'(SLAVE_BUSER), 32'(exp_e[EW-1:IDW+2]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic drive_aw(input logic [IDW-1:0] id, input logic [UW-1:0] user);
      int waited;
      waited = 0;
      SLAVE_AWID    = id;
      SLAVE_AWUSER  = user;
      SLAVE_AWVALID = 1'b1;
      while (!SLAVE_AWREADY && waited < 50) begin
         tick();
         waited++;
      end
      if (!SLAVE_AWREADY) check("aw_ready_timeout", 32'(SLAVE_AWREADY), 32'd1);
      tick();
      SLAVE_AWVALID = 1'b0;
   endtask

   task automatic drive_w(input int beats);
      int waited;
      for (int b = 0; b < beats; b++) begin
         waited       = 0;
         SLAVE_WVALID = 1'b1;
         SLAVE_WLAST  = (b == beats - 1);
         while (!SLAVE_WREADY && waited < 50) begin
            tick();
            waited++;
         end
         if (!SLAVE_WREADY) check("w_ready_timeout", 32'(SLAVE_WREADY), 32'd1);
         tick();
      end
      SLAVE_WVALID = 1'b0;
      SLAVE_WLAST  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [IDW-1:0] awid;
      logic [UW-1:0]  awuser;
      int             mode;   // 0: AW then W, 1: W then AW, 2: concurrent
      int             beats;
      logic [IDW-1:0] exp_bid;
      logic [UW-1:0]  exp_buser;
      logic [1:0]     exp_bresp;
   } vec_t;

   vec_t vecs[9];
   int   saw_b;

   initial begin
      for (int i = 0; i < 9; i++) begin
         vecs[i].awid      = IDW'($urandom_range(0, 15));
         vecs[i].awuser    = UW'(i);
         vecs[i].mode      = i % 3;
         vecs[i].beats     = $urandom_range(1, 4);
         vecs[i].exp_bid   = vecs[i].awid;
         vecs[i].exp_buser = user_exp(UW'(i));
         vecs[i].exp_bresp = 2'b11;
      end

      // ---- reset ----
      sysReset      = 1'b1;
      SLAVE_AWID    = '0;
      SLAVE_AWUSER  = '0;
      SLAVE_AWVALID = 1'b0;
      SLAVE_WLAST   = 1'b0;
      SLAVE_WVALID  = 1'b0;
      SLAVE_BREADY  = 1'b0;
      #1;
      check("rst_awready", 32'(SLAVE_AWREADY), 32'd0);
      check("rst_wready",  32'(SLAVE_WREADY),  32'd0);
      check("rst_bvalid",  32'(SLAVE_BVALID),  32'd0);
      check("rst_bid",     32'(SLAVE_BID),     32'd0);
      check("rst_bresp",   32'(SLAVE_BRESP),   32'd0);
      check("rst_buser",   32'(SLAVE_BUSER),   32'd0);
      repeat (2) tick();
      sysReset = 1'b0;
      check("rel_awready_low", 32'(SLAVE_AWREADY), 32'd0);
      tick();
      check("rel_awready_high", 32'(SLAVE_AWREADY), 32'd1);
      check("rel_wready_high",  32'(SLAVE_WREADY),  32'd1);

      // ---- single write, latency N+2, one-cycle BVALID ----
      SLAVE_BREADY = 1'b1;
      expect_b(4'd5, 2'd1);
      SLAVE_AWID    = 4'd5;
      SLAVE_AWUSER  = 2'd1;
      SLAVE_AWVALID = 1'b1;
      SLAVE_WVALID  = 1'b1;
      SLAVE_WLAST   = 1'b1;
      check("sw_awready", 32'(SLAVE_AWREADY), 32'd1);
      check("sw_wready",  32'(SLAVE_WREADY),  32'd1);
      tick();
      SLAVE_AWVALID = 1'b0;
      SLAVE_WVALID  = 1'b0;
      SLAVE_WLAST   = 1'b0;
      check("sw_bvalid_n1", 32'(SLAVE_BVALID), 32'd0);
      tick();
      check("sw_bvalid_n2", 32'(SLAVE_BVALID), 32'd1);
      check("sw_bid",       32'(SLAVE_BID),    32'd5);
      check("sw_bresp",     32'(SLAVE_BRESP),  32'd3);
      check("sw_buser",     32'(SLAVE_BUSER),  32'(user_exp(2'd1)));
      tick();
      check("sw_bvalid_one_cycle", 32'(SLAVE_BVALID), 32'd0);

      // ---- table-driven transactions ----
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back({vecs[i].exp_buser, vecs[i].exp_bid, vecs[i].exp_bresp});
         case (vecs[i].mode)
            0: begin
               drive_aw(vecs[i].awid, vecs[i].awuser);
               drive_w(vecs[i].beats);
            end
            1: begin
               drive_w(vecs[i].beats);
               drive_aw(vecs[i].awid, vecs[i].awuser);
            end
            default: begin
               fork
                  drive_aw(vecs[i].awid, vecs[i].awuser);
                  drive_w(vecs[i].beats);
               join
            end
         endcase
         wait_drain(50);
      end

      // ---- W before AW; WREADY drops at three unanswered bursts ----
      drive_w(1);
      drive_w(2);
      check("wfirst_wready_2", 32'(SLAVE_WREADY), 32'd1);
      drive_w(1);
      check("wfirst_wready_3", 32'(SLAVE_WREADY), 32'd0);
      check("wfirst_no_b",     32'(SLAVE_BVALID), 32'd0);
      expect_b(4'd1, 2'd0);
      expect_b(4'd2, 2'd3);
      expect_b(4'd7, 2'd2);
      drive_aw(4'd1, 2'd0);
      drive_aw(4'd2, 2'd3);
      drive_aw(4'd7, 2'd2);
      wait_drain(50);

      // ---- backpressure ----
      SLAVE_BREADY = 1'b0;
      expect_b(4'd3, 2'd0);
      expect_b(4'd4, 2'd1);
      expect_b(4'd6, 2'd2);
      drive_aw(4'd3, 2'd0);
      drive_aw(4'd4, 2'd1);
      drive_aw(4'd6, 2'd2);
      check("bp_awready_full", 32'(SLAVE_AWREADY), 32'd0);
      drive_w(2);
      drive_w(1);
      drive_w(3);
      for (int c = 0; c < 10; c++) begin
         check("bp_bvalid_held", 32'(SLAVE_BVALID), 32'd1);
         check("bp_bid_stable",  32'(SLAVE_BID),    32'd3);
         tick();
      end
      SLAVE_BREADY = 1'b1;
      tick();
      check("bp_b2_valid", 32'(SLAVE_BVALID), 32'd1);
      check("bp_b2_id",    32'(SLAVE_BID),    32'd4);
      tick();
      check("bp_b3_valid", 32'(SLAVE_BVALID), 32'd1);
      check("bp_b3_id",    32'(SLAVE_BID),    32'd6);
      tick();
      check("bp_done", 32'(SLAVE_BVALID), 32'd0);
      wait_drain(10);

      // ---- WLAST coinciding with a B handshake at wdone_cnt = 1 ----
      SLAVE_BREADY = 1'b0;
      expect_b(4'd8,  2'd0);
      expect_b(4'd9,  2'd1);
      expect_b(4'd10, 2'd3);
      drive_aw(4'd8,  2'd0);
      drive_aw(4'd9,  2'd1);
      drive_aw(4'd10, 2'd3);
      drive_w(1);
      drive_w(1);
      tick();
      check("sim_b8_valid", 32'(SLAVE_BVALID), 32'd1);
      check("sim_b8_id",    32'(SLAVE_BID),    32'd8);
      SLAVE_BREADY = 1'b1;
      SLAVE_WVALID = 1'b1;
      SLAVE_WLAST  = 1'b1;
      check("sim_wready", 32'(SLAVE_WREADY), 32'd1);
      tick();
      SLAVE_WVALID = 1'b0;
      SLAVE_WLAST  = 1'b0;
      check("sim_b9_valid", 32'(SLAVE_BVALID), 32'd1);
      check("sim_b9_id",    32'(SLAVE_BID),    32'd9);
      tick();
      check("sim_b10_valid", 32'(SLAVE_BVALID), 32'd1);
      check("sim_b10_id",    32'(SLAVE_BID),    32'd10);
      tick();
      check("sim_done", 32'(SLAVE_BVALID), 32'd0);
      wait_drain(10);

      // ---- reset with BVALID high and two commands pending ----
      SLAVE_BREADY = 1'b0;
      drive_aw(4'd11, 2'd1);
      drive_aw(4'd12, 2'd2);
      drive_aw(4'd13, 2'd3);
      drive_w(1);
      drive_w(1);
      drive_w(1);
      tick();
      check("mid_bvalid", 32'(SLAVE_BVALID), 32'd1);
      check("mid_bid",    32'(SLAVE_BID),    32'd11);
      #2;
      sysReset = 1'b1;
      #1;
      check("mid_rst_bvalid_async", 32'(SLAVE_BVALID),  32'd0);
      check("mid_rst_bid",          32'(SLAVE_BID),     32'd0);
      check("mid_rst_awready",      32'(SLAVE_AWREADY), 32'd0);
      exp_q.delete();
      repeat (2) tick();
      sysReset = 1'b0;
      tick();
      SLAVE_BREADY = 1'b1;
      saw_b = 0;
      for (int c = 0; c < 10; c++) begin
         if (SLAVE_BVALID) saw_b = 1;
         tick();
      end
      check("mid_no_stale_b", 32'(saw_b), 32'd0);
      expect_b(4'd14, 2'd1);
      fork
         drive_aw(4'd14, 2'd1);
         drive_w(2);
      join
      wait_drain(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
